multi_pulser: RTL and testbench

- Parametrised, multi-channel successor to the single-pulse generator.
- Each channel synchronises an asynchronous input (button, switch, external strobe), debounces it, and converts selected edges into a fixed-width output pulse.
- A per-block mode selects rising, falling, both-edge, or rising-with-auto-repeat triggering.
- Sits between raw board inputs and control logic; one instance serves a whole button bank.

---
 rtl/pulser_pkg.sv | 21 ++
 rtl/pulser_channel.sv | 154 +++++++++++++++
 rtl/multi_pulser.sv | 40 ++++
 tb/tb_multi_pulser.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pulser_pkg.sv
// Shared constants for the multi-channel pulse generator: trigger mode
// encodings, repeat FSM state encodings and a small sizing helper.
package pulser_pkg;

  // Trigger mode encodings (value of the shared 'mode' input)
  localparam logic [1:0] MODE_RISE   = 2'd0;
  localparam logic [1:0] MODE_FALL   = 2'd1;
  localparam logic [1:0] MODE_BOTH   = 2'd2;
  localparam logic [1:0] MODE_REPEAT = 2'd3;

  // Auto-repeat FSM states
  localparam logic [1:0] RPT_IDLE       = 2'd0;
  localparam logic [1:0] RPT_WAIT_FIRST = 2'd1;
  localparam logic [1:0] RPT_REPEAT     = 2'd2;

  // Larger of two values; used to size the shared repeat timer
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulser_channel.sv
// One channel: synchroniser, debouncer, edge qualification, auto-repeat FSM, pulse stretcher.
// Latency: input change stable before edge 1 shows on level/pulse at edge SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; free-running, outputs are plain registered levels.
module pulser_channel
  import pulser_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  input  logic [1:0] mode,
  output logic       pulse,
  output logic       level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PW_LOAD   = PW'(PULSE_CYCLES);
  localparam logic [TW-1:0] T_DELAY   = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_PERIOD  = TW'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DW-1:0]          db_cnt;
  logic                   accept;
  logic                   rise;
  logic                   fall;

  logic [1:0]             rpt_state;
  logic [1:0]             rpt_state_d;
  logic [TW-1:0]          timer;
  logic [TW-1:0]          timer_d;
  logic                   rpt_evt;

  logic                   evt;
  logic [PW-1:0]          pcnt;

  // Synchroniser: shift the raw input through SYNC_STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A level change is accepted on the clock where the run of differing
  // samples reaches DEBOUNCE_CYCLES.
  assign accept = (s != level) && (db_cnt == DB_LAST);
  assign rise   = accept && !level;
  assign fall   = accept &&  level;

  // Debouncer: count consecutive differing samples, toggle level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (s == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      level  <= ~level;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Auto-repeat next-state logic. The timer holds the number of clocks left
  // until the next repeat event, so an event fires when it would hit zero.
  // Leaving mode 3 or an accepted fall abandons the sequence without an event.
  always_comb begin
    rpt_state_d = rpt_state;
    timer_d     = timer;
    rpt_evt     = 1'b0;
    if ((mode != MODE_REPEAT) || fall) begin
      rpt_state_d = RPT_IDLE;
      timer_d     = '0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          if (rise) begin
            rpt_state_d = RPT_WAIT_FIRST;
            timer_d     = T_DELAY;
          end
        end
        RPT_WAIT_FIRST, RPT_REPEAT: begin
          if (timer <= TW'(1)) begin
            rpt_evt     = 1'b1;
            rpt_state_d = RPT_REPEAT;
            timer_d     = T_PERIOD;
          end else begin
            timer_d = timer - 1'b1;
          end
        end
        default: begin
          rpt_state_d = RPT_IDLE;
          timer_d     = '0;
        end
      endcase
    end
  end

  // Auto-repeat state and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_state <= RPT_IDLE;
      timer     <= '0;
    end else begin
      rpt_state <= rpt_state_d;
      timer     <= timer_d;
    end
  end

  // Qualify edges by the current mode; mode is sampled on the same edge the
  // event is registered, so earlier edges are never re-qualified.
  always_comb begin
    evt = 1'b0;
    case (mode)
      MODE_RISE:   evt = rise;
      MODE_FALL:   evt = fall;
      MODE_BOTH:   evt = rise | fall;
      MODE_REPEAT: evt = rise | rpt_evt;
      default:     evt = 1'b0;
    endcase
  end

  // Pulse stretcher: an event (re)loads the counter, so overlapping events
  // merge into one continuous pulse ending PULSE_CYCLES after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      pulse <= 1'b0;
    end else if (evt) begin
      pcnt  <= PW_LOAD;
      pulse <= 1'b1;
    end else begin
      if (pcnt != '0) begin
        pcnt <= pcnt - 1'b1;
      end
      pulse <= (pcnt > PW'(1));
    end
  end

endmodule

// File: rtl/multi_pulser.sv
// Multi-channel debounced edge-to-pulse generator for a bank of raw inputs.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES clocks from a stable input change to level/pulse.
// Backpressure: none; every channel runs independently every clock.
module multi_pulser
  import pulser_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] signal,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] level
);

  // One fully independent channel per input bit, all sharing the mode select
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulser_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_CYCLES    (PULSE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .signal (signal[i]),
      .mode   (mode),
      .pulse  (pulse[i]),
      .level  (level[i])
    );
  end

endmodule

// File: tb/tb_multi_pulser.sv
// Directed bench for multi_pulser: two instances (2- and 8-cycle pulses),
// per-edge comparison of pulse outputs against hand-computed pulse start edges.
module tb_multi_pulser;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [1:0] sig_a, sig_b;
  logic [1:0] pulse_a, pulse_b;
  logic [1:0] level_a, level_b;

  int n_checks = 0;
  int n_errors = 0;

  // Expected pulse start edges per channel, and scheduled input changes
  int         starts0[$];
  int         starts1[$];
  int         chg_e[$];
  logic [1:0] chg_v[$];

  multi_pulser #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(2), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .signal(sig_a), .mode(mode),
    .pulse(pulse_a), .level(level_a)
  );

  multi_pulser #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(8), .REPEAT_DELAY(10), .REPEAT_PERIOD(9)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .signal(sig_b), .mode(mode),
    .pulse(pulse_b), .level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released just after a rising edge; the next edge is edge 1
  task automatic do_reset();
    rst_n = 1'b0;
    sig_a = 2'b00;
    sig_b = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_plan();
    starts0.delete();
    starts1.delete();
    chg_e.delete();
    chg_v.delete();
  endtask

  // Run n edges, compare the pulse vector after each edge with the expected
  // pulses of width w beginning at the listed start edges, then apply any
  // input change scheduled for that edge (seen by the DUT from the next edge).
  task automatic run_win(input string tag, input int dut, input int n);
    int         w;
    logic       exp0, exp1;
    logic [1:0] got;
    w = (dut == 1) ? 8 : 2;
    for (int e = 1; e <= n; e++) begin
      tick();
      exp0 = 1'b0;
      exp1 = 1'b0;
      foreach (starts0[k]) if (e >= starts0[k] && e < starts0[k] + w) exp0 = 1'b1;
      foreach (starts1[k]) if (e >= starts1[k] && e < starts1[k] + w) exp1 = 1'b1;
      got = (dut == 1) ? pulse_b : pulse_a;
      check($sformatf("%s pulse@e%0d", tag, e), {30'd0, got}, {30'd0, exp1, exp0});
      foreach (chg_e[k]) begin
        if (chg_e[k] == e) begin
          if (dut == 1) sig_b = chg_v[k];
          else          sig_a = chg_v[k];
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 2'd0;
    sig_a = 2'b00;
    sig_b = 2'b00;
    #1;
    check("reset pulse_a", {30'd0, pulse_a}, 32'd0);
    check("reset level_a", {30'd0, level_a}, 32'd0);
    check("reset pulse_b", {30'd0, pulse_b}, 32'd0);

    // Clean rise, mode 0: pulse at edges 6-7, channel 1 untouched
    do_reset();
    clear_plan();
    mode  = 2'd0;
    sig_a = 2'b01;
    starts0 = '{6};
    run_win("rise", 0, 12);
    check("rise level", {30'd0, level_a}, 32'd1);

    // 3-clock glitch is rejected
    do_reset();
    clear_plan();
    sig_a = 2'b01;
    chg_e = '{3};
    chg_v = '{2'b00};
    run_win("glitch3", 0, 14);
    check("glitch3 level", {30'd0, level_a}, 32'd0);

    // 4-clock high is just long enough: one pulse, fall ignored in mode 0
    do_reset();
    clear_plan();
    sig_a = 2'b01;
    chg_e = '{4};
    chg_v = '{2'b00};
    starts0 = '{6};
    run_win("high4", 0, 14);
    check("high4 level", {30'd0, level_a}, 32'd0);

    // Both-edge mode: high 20 clocks -> pulses at edges 6 and 26
    do_reset();
    clear_plan();
    mode  = 2'd2;
    sig_a = 2'b01;
    chg_e = '{20};
    chg_v = '{2'b00};
    starts0 = '{6, 26};
    run_win("both", 0, 32);

    // Auto-repeat: high 40 clocks; fall accepted at 46 emits nothing
    do_reset();
    clear_plan();
    mode  = 2'd3;
    sig_a = 2'b01;
    chg_e = '{40};
    chg_v = '{2'b00};
    starts0 = '{6, 16, 21, 26, 31, 36, 41};
    run_win("repeat", 0, 60);
    check("repeat level", {30'd0, level_a}, 32'd0);

    // Both channels rising together pulse on the same edge
    do_reset();
    clear_plan();
    mode  = 2'd0;
    sig_a = 2'b11;
    starts0 = '{6};
    starts1 = '{6};
    run_win("simul", 0, 10);
    check("simul level", {30'd0, level_a}, 32'd3);

    // Retrigger, 8-cycle pulse, mode 2: the debouncer spaces accepted edges
    // at least 4 clocks apart, so rise at 6 and fall at 10 give one merged
    // pulse high on edges 6..17 (12 clocks) with no gap.
    do_reset();
    clear_plan();
    mode  = 2'd2;
    sig_b = 2'b01;
    chg_e = '{4};
    chg_v = '{2'b00};
    starts0 = '{6, 10};
    run_win("retrig", 1, 22);

    // Entering mode 3 while level is already high does not start repeats
    do_reset();
    clear_plan();
    mode  = 2'd0;
    sig_a = 2'b01;
    starts0 = '{6};
    run_win("pre_m3", 0, 12);
    mode = 2'd3;
    starts0.delete();
    run_win("into_m3", 0, 25);

    // Async reset mid-pulse clears outputs with no clock edge, then a held
    // input produces a fresh rise and a fresh repeat sequence.
    do_reset();
    clear_plan();
    mode  = 2'd3;
    sig_a = 2'b01;
    for (int e = 1; e <= 6; e++) tick();
    check("pre-reset pulse", {30'd0, pulse_a}, 32'd1);
    check("pre-reset level", {30'd0, level_a}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst pulse", {30'd0, pulse_a}, 32'd0);
    check("async rst level", {30'd0, level_a}, 32'd0);
    tick();
    check("held rst pulse", {30'd0, pulse_a}, 32'd0);
    rst_n = 1'b1;
    starts0 = '{6, 16};
    run_win("post_rst", 0, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
